// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI motor frame controller.
// SPI_CHECKSUM_EN selects the 24-bit checksummed frame instead of the 16-bit frame.
package spi_ctrl_pkg;

    localparam int unsigned CMD_W       = 8;
    localparam int unsigned FRAME_CNT_W = 6;

`ifdef SPI_CHECKSUM_EN
    localparam int unsigned FRAME_BITS = 24;
`else
    localparam int unsigned FRAME_BITS = 16;
`endif

    // Bit counter saturates at FRAME_BITS+1 so over-long frames stay distinguishable.
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int unsigned M1_LSB = FRAME_BITS - CMD_W;
    localparam int unsigned M2_LSB = FRAME_BITS - 2 * CMD_W;

    localparam logic [CMD_W-1:0] CHK_CONST = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_COMMIT
    } state_e;

    // Status byte returned on sdo, MSB first: {timeout, err_sticky, frame_cnt}.
    typedef struct packed {
        logic                   timeout;
        logic                   err;
        logic [FRAME_CNT_W-1:0] frame_cnt;
    } status_t;

    function automatic logic [CMD_W-1:0] frame_checksum(input logic [CMD_W-1:0] m1,
                                                        input logic [CMD_W-1:0] m2);
        return m1 ^ m2 ^ CHK_CONST;
    endfunction

endpackage

// File: rtl/spi_motor_ctrl_if.sv
// SPI pins plus committed motor command outputs of the frame controller.
interface spi_motor_ctrl_if;
    import spi_ctrl_pkg::*;

    logic             sck;
    logic             sdi;
    logic             ce;
    logic             sdo;
    logic [CMD_W-1:0] motor1;
    logic [CMD_W-1:0] motor2;
    logic             cmd_valid;
    logic             frame_err;
    logic             timeout;

    modport master (
        output sck, sdi, ce,
        input  sdo, motor1, motor2, cmd_valid, frame_err, timeout
    );

    modport slave (
        input  sck, sdi, ce,
        output sdo, motor1, motor2, cmd_valid, frame_err, timeout
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with an extra history flop providing rise/fall pulses.
module sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_c_o,
    output logic [W-1:0] fall_c_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o  = sync_q;
    assign rise_c_o = sync_q & ~prev_q;
    assign fall_c_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_motor_ctrl.sv
// SPI frame controller: validates host frames and commits motor commands atomically.
// Define SPI_CHECKSUM_EN for 24-bit frames carrying a checksum byte.
module spi_motor_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned      WDOG_CYCLES = 2_400_000,
    parameter logic [CMD_W-1:0] SAFE_CMD    = 8'h00
) (
    input  logic            clk,
    input  logic            reset_n,
    spi_motor_ctrl_if.slave bus
);

    localparam int unsigned       WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic ce_lvl, ce_rise, ce_fall;

    sync_edge #(.W(1)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d_i(bus.sck),
        .level_o(sck_lvl), .rise_c_o(sck_rise), .fall_c_o(sck_fall)
    );
    sync_edge #(.W(1)) u_sync_sdi (
        .clk(clk), .reset_n(reset_n), .d_i(bus.sdi),
        .level_o(sdi_lvl), .rise_c_o(sdi_rise), .fall_c_o(sdi_fall)
    );
    sync_edge #(.W(1)) u_sync_ce (
        .clk(clk), .reset_n(reset_n), .d_i(bus.ce),
        .level_o(ce_lvl), .rise_c_o(ce_rise), .fall_c_o(ce_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, sdi_rise, sdi_fall};

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]        motor1_q, motor1_d;
    logic [CMD_W-1:0]        motor2_q, motor2_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    timeout_q, timeout_d;
    logic                    err_sticky_q, err_sticky_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic [7:0]              sdo_sr_q, sdo_sr_d;
    logic                    chk_ok_c;
    status_t                 status_c;

`ifdef SPI_CHECKSUM_EN
    assign chk_ok_c = (shift_q[CMD_W-1:0] ==
                       frame_checksum(shift_q[M1_LSB +: CMD_W], shift_q[M2_LSB +: CMD_W]));
`else
    assign chk_ok_c = 1'b1;
`endif

    assign status_c = '{timeout: timeout_q, err: err_sticky_q, frame_cnt: frame_cnt_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (ce_lvl) state_d = ST_SHIFT;
            ST_SHIFT:  if (ce_fall) state_d = (bit_cnt_q == CNT_FULL) ? ST_CHECK : ST_IDLE;
            ST_CHECK:  state_d = chk_ok_c ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        motor1_d     = motor1_q;
        motor2_d     = motor2_q;
        cmd_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        timeout_d    = timeout_q;
        err_sticky_d = err_sticky_q;
        frame_cnt_d  = frame_cnt_q;
        wdog_d       = wdog_q;
        sdo_sr_d     = sdo_sr_q;

        unique case (state_q)
            ST_IDLE: bit_cnt_d = '0;
            ST_SHIFT: begin
                if (sck_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], sdi_lvl};
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (ce_fall && (bit_cnt_q != CNT_FULL)) frame_err_d = 1'b1;
            end
            ST_CHECK: if (!chk_ok_c) frame_err_d = 1'b1;
            default: ;
        endcase

        // A commit in the same cycle as watchdog expiry takes priority.
        if (state_q == ST_COMMIT) begin
            motor1_d    = shift_q[M1_LSB +: CMD_W];
            motor2_d    = shift_q[M2_LSB +: CMD_W];
            cmd_valid_d = 1'b1;
            wdog_d      = WDOG_LOAD;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            timeout_d   = 1'b0;
        end else if (wdog_q == '0) begin
            motor1_d  = SAFE_CMD;
            motor2_d  = SAFE_CMD;
            timeout_d = 1'b1;
        end else begin
            wdog_d = wdog_q - WDOG_W'(1);
        end

        // Status is snapshotted at frame start and shifted out on sck falls.
        if (ce_rise) begin
            sdo_sr_d     = status_c;
            err_sticky_d = 1'b0;
        end else if (sck_fall) begin
            sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
        end
        if (frame_err_d) err_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            motor1_q     <= SAFE_CMD;
            motor2_q     <= SAFE_CMD;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b1;
            err_sticky_q <= 1'b0;
            frame_cnt_q  <= '0;
            wdog_q       <= '0;
            sdo_sr_q     <= '0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            motor1_q     <= motor1_d;
            motor2_q     <= motor2_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
            err_sticky_q <= err_sticky_d;
            frame_cnt_q  <= frame_cnt_d;
            wdog_q       <= wdog_d;
            sdo_sr_q     <= sdo_sr_d;
        end
    end

    assign bus.sdo       = sdo_sr_q[7];
    assign bus.motor1    = motor1_q;
    assign bus.motor2    = motor2_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;

endmodule
